// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions (operation encoding, data width, op-legality helper).
package alu_pkg;

  localparam int         DATA_W     = 32;
  localparam logic [3:0] ALU_OP_MAX = 4'd9;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // An op code above the last defined operation is illegal; the ALU returns zero for it.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/ALU.sv
// ALU: existing combinational 32-bit ALU. Undefined op codes produce a zero result.
module ALU
  import alu_pkg::*;
(
  input  logic [3:0]        ALUOp,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  // Operation decode; shift amounts use the low five bits of B.
  always_comb begin
    Result = {DATA_W{1'b0}};
    case (ALUOp)
      ALU_ADD:  Result = A + B;
      ALU_SUB:  Result = A - B;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_XOR:  Result = A ^ B;
      ALU_SLL:  Result = A << B[4:0];
      ALU_SRL:  Result = A >> B[4:0];
      ALU_SRA:  Result = $signed(A) >>> B[4:0];
      ALU_SLT:  Result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: Result = {{(DATA_W-1){1'b0}}, (A < B)};
      default:  Result = {DATA_W{1'b0}};
    endcase
  end

  // Zero flag follows the result.
  always_comb begin
    Zero = (Result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker. Scans req starting at ptr, wrapping
// modulo N, and returns the first requester found as a one-hot grant plus its index.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  // One extra bit so ptr + k cannot overflow before the wrap subtraction.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0]    sum_s;
  logic [IDX_W-1:0] idx_s;

  // Priority scan ptr, ptr+1, ... mod N; the first asserted request wins.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IDX_W{1'b0}};
    grant_vld = 1'b0;
    sum_s     = {SW{1'b0}};
    idx_s     = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr} + SW'(k);
      if (sum_s >= SW'(N)) begin
        sum_s = sum_s - SW'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDX_W-1:0];
      if (!grant_vld && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        grant_vld    = 1'b1;
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NUM_REQ requesters with round-robin arbitration.
// A single response register holds {id, result, zero, err}; it can drain and reload
// on the same edge, giving one op per cycle with one cycle of latency.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataA,
  input  logic [NUM_REQ*DATA_W-1:0]   req_dataB,
  input  logic [NUM_REQ*4-1:0]        req_op,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_result,
  output logic                        rsp_zero,
  output logic                        rsp_err,
  output logic [15:0]                 busy_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Arbitration and ALU datapath
  logic                can_issue_s;
  logic [NUM_REQ-1:0]  pick_req_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                grant_vld_s;
  logic [DATA_W-1:0]   alu_a_s;
  logic [DATA_W-1:0]   alu_b_s;
  logic [3:0]          alu_op_s;
  logic [DATA_W-1:0]   alu_res_s;
  logic                alu_zero_s;
  logic                op_err_s;
  logic [ID_W-1:0]     ptr_next_s;

  // Registered state
  logic                rsp_valid_q,  rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,     rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q,   rsp_zero_d;
  logic                rsp_err_q,    rsp_err_d;
  logic [15:0]         busy_cnt_q,   busy_cnt_d;
  logic [ID_W-1:0]     ptr_q,        ptr_d;

  // Issue is allowed when the response slot is free or drains this cycle; never in reset.
  always_comb begin
    can_issue_s = rst_n & (~rsp_valid_q | rsp_ready);
    pick_req_s  = req_valid & {NUM_REQ{can_issue_s}};
    req_ready   = grant_s;
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req       (pick_req_s),
    .ptr       (ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_vld (grant_vld_s)
  );

  // Operand/op mux selected by the granted requester's index.
  always_comb begin
    alu_a_s  = req_dataA[grant_idx_s*DATA_W +: DATA_W];
    alu_b_s  = req_dataB[grant_idx_s*DATA_W +: DATA_W];
    alu_op_s = req_op[grant_idx_s*4 +: 4];
  end

  ALU u_alu (
    .ALUOp  (alu_op_s),
    .A      (alu_a_s),
    .B      (alu_b_s),
    .Result (alu_res_s),
    .Zero   (alu_zero_s)
  );

  // Error flag comes from the op code itself, independent of what the ALU returned.
  always_comb begin
    op_err_s = is_illegal_op(alu_op_s);
  end

  // Pointer advances to the requester just after the one granted, wrapping at NUM_REQ.
  always_comb begin
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = {ID_W{1'b0}};
    end else begin
      ptr_next_s = grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Next state: load on grant (covers drain-and-reload), clear on drain, else hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    busy_cnt_d   = busy_cnt_q;
    ptr_d        = ptr_q;
    if (grant_vld_s) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_idx_s;
      rsp_result_d = alu_res_s;
      rsp_zero_d   = alu_zero_s;
      rsp_err_d    = op_err_s;
      ptr_d        = ptr_next_s;
      if (busy_cnt_q != CNT_MAX) begin
        busy_cnt_d = busy_cnt_q + 16'd1;
      end else begin
        busy_cnt_d = busy_cnt_q;
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= {ID_W{1'b0}};
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_cnt_q   <= 16'd0;
      ptr_q        <= {ID_W{1'b0}};
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      busy_cnt_q   <= busy_cnt_d;
      ptr_q        <= ptr_d;
    end
  end

  // Outputs straight from the registers.
  always_comb begin
    rsp_valid  = rsp_valid_q;
    rsp_id     = rsp_id_q;
    rsp_result = rsp_result_q;
    rsp_zero   = rsp_zero_q;
    rsp_err    = rsp_err_q;
    busy_cnt   = busy_cnt_q;
  end

endmodule
